key_matrix_scanner: RTL

- Input-side counterpart of the LED matrix display path. Scans an 8x8 switch/button matrix by driving one row at a time and sensing the columns.
- Debounces every key and presents a 64-bit debounced key map in the same flattened layout as the display grid: bits [8r+7:8r] = row r, bit c within the row = column c.
- Queues press/release events in a small FIFO with a valid/ready handshake for game logic.

---
 rtl/key_matrix_scanner.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/key_matrix_scanner.sv
// 8x8 key matrix scanner. It drives one row at a time, senses the columns,
// debounces every key and queues press/release events in a valid/ready FIFO.
module key_matrix_scanner #(
   parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
   parameter int unsigned SCAN_HZ        = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 3,
   parameter int unsigned EVT_DEPTH      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [7:0]  key_row_drive,
   input  logic [7:0]  key_col_sense,
   output logic [63:0] key_state,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [5:0]  evt_code,
   output logic        evt_press,
   output logic        evt_overflow,
   output logic        frame_done
);

   localparam int unsigned CYCLES_PER_ROW = CLK_FREQ_HZ / (SCAN_HZ * 8);
   localparam int unsigned DW = $clog2(CYCLES_PER_ROW);
   localparam int unsigned AW = $clog2(EVT_DEPTH);

   if (CYCLES_PER_ROW < 4) begin : gen_cpr_check
      $error("CYCLES_PER_ROW must be at least 4");
   end
   if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 3) begin : gen_db_check
      $error("DEBOUNCE_SCANS must be in 1..3");
   end
   if (EVT_DEPTH < 2 || (EVT_DEPTH & (EVT_DEPTH - 1)) != 0) begin : gen_depth_check
      $error("EVT_DEPTH must be a power of 2, at least 2");
   end

   typedef enum logic [0:0] {StDwell, StEval} state_t;

   state_t        state;
   logic [2:0]    row;
   logic [2:0]    col;
   logic [DW-1:0] dwell;
   logic [7:0]    sample;
   logic [7:0]    sync_meta;
   logic [7:0]    sync_col;
   logic [1:0]    cnt [64];

   logic [5:0]    key_idx;
   logic          key_differs;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [2:0]    row_next;

   logic [5:0]    fifo_code  [EVT_DEPTH];
   logic          fifo_press [EVT_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   // Two-flop synchronizer for the asynchronous column inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '0;
         sync_col  <= '0;
      end else begin
         sync_meta <= key_col_sense;
         sync_col  <= sync_meta;
      end
   end

   // Key under evaluation and whether its debounce counter has run out.
   always_comb begin
      key_idx     = {row, col};
      key_differs = (state == StEval) && (sample[col] != key_state[key_idx]);
      push        = key_differs && (cnt[key_idx] == 2'(DEBOUNCE_SCANS - 1));
      row_next    = row + 3'd1;
   end

   // Scan FSM: dwell on a row, capture the columns, then walk the 8 keys.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= StDwell;
         row           <= '0;
         col           <= '0;
         dwell         <= '0;
         sample        <= '0;
         key_row_drive <= 8'h01;
         frame_done    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            StDwell: begin
               if (dwell == DW'(CYCLES_PER_ROW - 1)) begin
                  sample <= sync_col;
                  col    <= '0;
                  state  <= StEval;
               end else begin
                  dwell <= dwell + DW'(1);
               end
            end
            StEval: begin
               col <= col + 3'd1;
               if (col == 3'd7) begin
                  row           <= row_next;
                  key_row_drive <= 8'h01 << row_next;
                  dwell         <= '0;
                  state         <= StDwell;
                  frame_done    <= (row == 3'd7);
               end
            end
            default: state <= StDwell;
         endcase
      end
   end

   // Per-key debounce: a key flips only after enough consecutive disagreeing frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_state <= '0;
         for (int i = 0; i < 64; i++) cnt[i] <= '0;
      end else if (state == StEval) begin
         if (!key_differs) begin
            cnt[key_idx] <= '0;
         end else if (push) begin
            key_state[key_idx] <= sample[col];
            cnt[key_idx]       <= '0;
         end else begin
            cnt[key_idx] <= cnt[key_idx] + 2'd1;
         end
      end
   end

   // FIFO status and head; head fields read as zero while empty.
   always_comb begin
      empty     = (wr_ptr == rd_ptr);
      full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      evt_valid = !empty;
      pop       = evt_valid && evt_ready;
      evt_code  = empty ? 6'd0 : fifo_code[rd_ptr[AW-1:0]];
      evt_press = empty ? 1'b0 : fifo_press[rd_ptr[AW-1:0]];
   end

   // FIFO pointers and sticky overflow; a pop frees the slot for a same-cycle push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         evt_overflow <= 1'b0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push) begin
            if (!full || pop) wr_ptr <= wr_ptr + 1'b1;
            else              evt_overflow <= 1'b1;
         end
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push && (!full || pop)) begin
         fifo_code[wr_ptr[AW-1:0]]  <= key_idx;
         fifo_press[wr_ptr[AW-1:0]] <= sample[col];
      end
   end

endmodule
